alarm_scheduler: RTL and testbench
==================================

Name: alarm_scheduler

Overview:
- Multi-slot alarm controller for the clock design.
- Holds SLOTS programmable alarm times and compares them against the running real-clock time once per second.
- Arbitrates matching alarms onto the single ring resource (sig_ring feeds the flow_led sig_ring input).
- Sequences ring / snooze / dismiss with per-second timers.

Parameters:
WIDTH, 32, width of sec/min/hour time values
SLOTS, 4, number of alarm slots
SLOT_W, 2, slot index width (log2 SLOTS)
RING_LEN, 30, ring duration in sec_tick pulses before auto-stop
SNOOZE_LEN, 300, snooze duration in sec_tick pulses

Ports:
clk_src  input  1  system clock; all state on posedge
reset  input  1  asynchronous, active-high reset
sec_tick  input  1  one-clk_src-cycle pulse per real-clock second
sec  input  WIDTH  current real-clock seconds
min  input  WIDTH  current real-clock minutes
hour  input  WIDTH  current real-clock hours
wr_en  input  1  write strobe for slot programming
wr_slot  input  SLOT_W  slot index to write
wr_sec  input  WIDTH  alarm seconds to store
wr_min  input  WIDTH  alarm minutes to store
wr_hour  input  WIDTH  alarm hours to store
wr_arm  input  1  armed bit to store
dismiss  input  1  level; stop current alarm
snooze  input  1  level; snooze current alarm
sig_ring  output  1  high while in RINGING
active_slot  output  SLOT_W  slot currently being serviced
armed  output  SLOTS  armed bit per slot
pending  output  SLOTS  matched-but-not-yet-serviced bit per slot

Behaviour:
- Reset (async, immediate): all slot times, armed, pending = 0; state IDLE; ring_cnt = snooze_cnt = 0; active_slot = 0; sig_ring = 0.
- Slot write: on a clock edge with wr_en, slot[wr_slot] takes {wr_hour, wr_min, wr_sec, wr_arm}.
  - The write also clears pending[wr_slot]; the clear beats a same-edge match set.
  - Writing the active slot with wr_arm = 0 while in RINGING or SNOOZE forces IDLE on that edge.
- Match: on an edge with sec_tick = 1, each slot i with armed[i] and an exact full-WIDTH equality of sec, min and hour to its stored time sets pending[i].
  - Compares use the stored values before any same-edge write.
  - Without sec_tick, no matching occurs.
- FSM states: IDLE, RINGING, SNOOZE. sig_ring = (state == RINGING), decoded directly from the state register.
- IDLE:
  - If pending != 0, select the lowest set index.
  - On that edge: active_slot <= index, pending[index] cleared, ring_cnt <= RING_LEN, state <= RINGING.
  - Latency: sec_tick sampled at edge N sets pending; RINGING is entered at edge N+1; sig_ring is high after edge N+1.
- RINGING (priority high to low):
  - dismiss -> IDLE.
  - snooze -> SNOOZE, snooze_cnt <= SNOOZE_LEN.
  - sec_tick with ring_cnt == 1 -> IDLE (timeout).
  - sec_tick -> ring_cnt - 1.
  - Otherwise hold.
  - dismiss and snooze together: dismiss wins.
- SNOOZE:
  - dismiss -> IDLE.
  - sec_tick with snooze_cnt == 1 -> RINGING, ring_cnt <= RING_LEN, same active_slot.
  - sec_tick -> snooze_cnt - 1.
  - snooze input is ignored in SNOOZE.
- Queuing: matches during RINGING/SNOOZE accumulate in pending. They are serviced in index order after return to IDLE, one IDLE cycle between alarms.
- Re-match of the active slot while it is being serviced sets its pending bit (serviced again later).
- Dismiss does not disarm a slot; the alarm repeats daily.
- Counters saturate at neither end: loads always come from parameters, and 0 is never reached while counting.
- Outputs armed and pending are direct register values.

Test Plan:
- Write slot 2 = 07:30:00 armed; drive time to 07:30:00 with sec_tick -> pending = 4'b0100 after edge N, sig_ring = 1 and active_slot = 2 after edge N+1, pending = 0.
- Ring with no input for RING_LEN = 30 sec_ticks -> sig_ring drops to 0 after the 30th tick; state IDLE; armed[2] still 1.
- Slots 1 and 3 both = 12:00:00 armed, matching tick -> slot 1 rings first; dismiss -> one IDLE cycle, then slot 3 rings with active_slot = 3.
- Ringing, assert snooze -> sig_ring = 0; after SNOOZE_LEN = 300 sec_ticks sig_ring = 1 again on the same slot. Assert snooze and dismiss together while ringing -> IDLE, no snooze.
- Slot 0 unarmed but matching time -> pending stays 0. Rewrite active slot 0 with wr_arm = 0 while ringing -> sig_ring = 0 next edge. Write slot 1 on the same edge as its match -> pending[1] = 0.
- Assert reset mid-RINGING and mid-SNOOZE -> sig_ring, armed, pending, active_slot = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: stores SLOTS alarm times, matches them against the
// real-clock time on each sec_tick and sequences ring / snooze / dismiss for one slot at a time.
module alarm_scheduler #(
    parameter int WIDTH      = 32,
    parameter int SLOTS      = 4,
    parameter int SLOT_W     = 2,
    parameter int RING_LEN   = 30,
    parameter int SNOOZE_LEN = 300
) (
    input  logic              clk_src,
    input  logic              reset,
    input  logic              sec_tick,
    input  logic [WIDTH-1:0]  sec,
    input  logic [WIDTH-1:0]  min,
    input  logic [WIDTH-1:0]  hour,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [WIDTH-1:0]  wr_sec,
    input  logic [WIDTH-1:0]  wr_min,
    input  logic [WIDTH-1:0]  wr_hour,
    input  logic              wr_arm,
    input  logic              dismiss,
    input  logic              snooze,
    output logic              sig_ring,
    output logic [SLOT_W-1:0] active_slot,
    output logic [SLOTS-1:0]  armed,
    output logic [SLOTS-1:0]  pending
);

    localparam int MAX_LEN = (RING_LEN > SNOOZE_LEN) ? RING_LEN : SNOOZE_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  ringCnt_q, ringCnt_d;
    logic [CNT_W-1:0]  snoozeCnt_q, snoozeCnt_d;
    logic [SLOT_W-1:0] activeSlot_q, activeSlot_d;
    logic [SLOTS-1:0]  armed_q, armed_d;
    logic [SLOTS-1:0]  pending_q, pending_d;

    logic [WIDTH-1:0]  slotSec_q  [SLOTS];
    logic [WIDTH-1:0]  slotMin_q  [SLOTS];
    logic [WIDTH-1:0]  slotHour_q [SLOTS];

    logic [SLOTS-1:0]  matchVec;
    logic [SLOTS-1:0]  serviceMask;
    logic [SLOTS-1:0]  writeMask;
    logic [SLOT_W-1:0] lowIdx;
    logic              startService;
    logic              disarmActive;

    // Matching always looks at the stored times, so a same-edge write cannot affect it.
    always_comb begin
        matchVec = '0;
        for (int i = 0; i < SLOTS; i++) begin
            matchVec[i] = sec_tick && armed_q[i] &&
                          (sec  == slotSec_q[i]) &&
                          (min  == slotMin_q[i]) &&
                          (hour == slotHour_q[i]);
        end
    end

    always_comb begin
        lowIdx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowIdx = SLOT_W'(i);
            end
        end
    end

    assign startService = (state_q == IDLE) && (pending_q != '0);
    assign serviceMask  = startService ? (SLOTS'(1) << lowIdx) : '0;
    assign writeMask    = wr_en ? (SLOTS'(1) << wr_slot) : '0;
    assign disarmActive = wr_en && !wr_arm && (wr_slot == activeSlot_q) && (state_q != IDLE);

    // A new match wins over the service clear; a slot write wins over both.
    always_comb begin
        pending_d = ((pending_q & ~serviceMask) | matchVec) & ~writeMask;
        armed_d   = armed_q;
        if (wr_en) begin
            armed_d[wr_slot] = wr_arm;
        end
    end

    always_comb begin
        state_d      = state_q;
        ringCnt_d    = ringCnt_q;
        snoozeCnt_d  = snoozeCnt_q;
        activeSlot_d = activeSlot_q;
        case (state_q)
            IDLE: begin
                if (startService) begin
                    activeSlot_d = lowIdx;
                    ringCnt_d    = CNT_W'(RING_LEN);
                    state_d      = RINGING;
                end
            end
            RINGING: begin
                if (dismiss) begin
                    state_d = IDLE;
                end else if (snooze) begin
                    state_d     = SNOOZE;
                    snoozeCnt_d = CNT_W'(SNOOZE_LEN);
                end else if (sec_tick) begin
                    if (ringCnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        ringCnt_d = ringCnt_q - CNT_W'(1);
                    end
                end
            end
            SNOOZE: begin
                if (dismiss) begin
                    state_d = IDLE;
                end else if (sec_tick) begin
                    if (snoozeCnt_q == CNT_W'(1)) begin
                        state_d   = RINGING;
                        ringCnt_d = CNT_W'(RING_LEN);
                    end else begin
                        snoozeCnt_d = snoozeCnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Disarming the slot being serviced abandons it regardless of dismiss/snooze/timers.
        if (disarmActive) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_src or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ringCnt_q    <= '0;
            snoozeCnt_q  <= '0;
            activeSlot_q <= '0;
            armed_q      <= '0;
            pending_q    <= '0;
        end else begin
            state_q      <= state_d;
            ringCnt_q    <= ringCnt_d;
            snoozeCnt_q  <= snoozeCnt_d;
            activeSlot_q <= activeSlot_d;
            armed_q      <= armed_d;
            pending_q    <= pending_d;
        end
    end

    always_ff @(posedge clk_src or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                slotSec_q[i]  <= '0;
                slotMin_q[i]  <= '0;
                slotHour_q[i] <= '0;
            end
        end else if (wr_en) begin
            slotSec_q[wr_slot]  <= wr_sec;
            slotMin_q[wr_slot]  <= wr_min;
            slotHour_q[wr_slot] <= wr_hour;
        end
    end

    assign sig_ring    = (state_q == RINGING);
    assign active_slot = activeSlot_q;
    assign armed       = armed_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler: directed scenarios then random traffic,
// each cycle's expected outputs come from a behavioural model and are checked by a monitor.
module tb_alarm_scheduler;

    localparam int SLOTS      = 4;
    localparam int RING_LEN   = 30;
    localparam int SNOOZE_LEN = 300;

    typedef struct {
        bit tick;
        int hr;
        int mn;
        int sc;
        bit we;
        int ws;
        int wh;
        int wm;
        int wsc;
        bit warm;
        bit dis;
        bit snz;
    } stim_t;

    typedef struct {
        bit ring;
        int active;
        int armedV;
        int pendV;
    } exp_t;

    logic        clk_src = 1'b0;
    logic        reset   = 1'b0;
    logic        sec_tick = 1'b0;
    logic [31:0] sec = '0, min = '0, hour = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_slot = '0;
    logic [31:0] wr_sec = '0, wr_min = '0, wr_hour = '0;
    logic        wr_arm = 1'b0;
    logic        dismiss = 1'b0;
    logic        snooze = 1'b0;
    logic        sig_ring;
    logic [1:0]  active_slot;
    logic [3:0]  armed;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;
    exp_t expQ[$];

    // Model state: mode 0 = quiet, 1 = ringing, 2 = snoozing.
    int mMode, mActive, mRingLeft, mSnoozeLeft;
    int mHour[SLOTS], mMin[SLOTS], mSec[SLOTS];
    bit mArmed[SLOTS], mPend[SLOTS];
    int curH = 0, curM = 0, curS = 0;

    alarm_scheduler dut (
        .clk_src(clk_src), .reset(reset), .sec_tick(sec_tick),
        .sec(sec), .min(min), .hour(hour),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_sec(wr_sec), .wr_min(wr_min),
        .wr_hour(wr_hour), .wr_arm(wr_arm), .dismiss(dismiss), .snooze(snooze),
        .sig_ring(sig_ring), .active_slot(active_slot), .armed(armed), .pending(pending)
    );

    always #5 clk_src = ~clk_src;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void modelReset();
        mMode = 0; mActive = 0; mRingLeft = 0; mSnoozeLeft = 0;
        for (int i = 0; i < SLOTS; i++) begin
            mHour[i] = 0; mMin[i] = 0; mSec[i] = 0; mArmed[i] = 0; mPend[i] = 0;
        end
    endfunction

    function automatic exp_t modelView();
        exp_t e;
        e.ring = (mMode == 1);
        e.active = mActive;
        e.armedV = 0;
        e.pendV = 0;
        for (int i = 0; i < SLOTS; i++) begin
            if (mArmed[i]) e.armedV |= (1 << i);
            if (mPend[i])  e.pendV  |= (1 << i);
        end
        return e;
    endfunction

    function automatic void modelStep(input stim_t s);
        bit hit[SLOTS];
        int oldMode = mMode;
        int oldActive = mActive;
        int first = -1;
        for (int i = 0; i < SLOTS; i++)
            hit[i] = s.tick && mArmed[i] && s.hr == mHour[i] && s.mn == mMin[i] && s.sc == mSec[i];
        for (int i = 0; i < SLOTS; i++) begin
            if (mPend[i]) begin
                first = i;
                break;
            end
        end
        if (oldMode == 0) begin
            if (first >= 0) begin
                mActive = first;
                mPend[first] = 0;
                mRingLeft = RING_LEN;
                mMode = 1;
            end
        end else if (oldMode == 1) begin
            if (s.dis) mMode = 0;
            else if (s.snz) begin
                mMode = 2;
                mSnoozeLeft = SNOOZE_LEN;
            end else if (s.tick) begin
                mRingLeft--;
                if (mRingLeft == 0) mMode = 0;
            end
        end else begin
            if (s.dis) mMode = 0;
            else if (s.tick) begin
                mSnoozeLeft--;
                if (mSnoozeLeft == 0) begin
                    mMode = 1;
                    mRingLeft = RING_LEN;
                end
            end
        end
        if (s.we && !s.warm && s.ws == oldActive && oldMode != 0) mMode = 0;
        for (int i = 0; i < SLOTS; i++)
            if (hit[i]) mPend[i] = 1;
        if (s.we) begin
            mPend[s.ws] = 0;
            mArmed[s.ws] = s.warm;
            mHour[s.ws] = s.wh;
            mMin[s.ws] = s.wm;
            mSec[s.ws] = s.wsc;
        end
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s.tick = 0; s.hr = curH; s.mn = curM; s.sc = curS;
        s.we = 0; s.ws = 0; s.wh = 0; s.wm = 0; s.wsc = 0; s.warm = 0;
        s.dis = 0; s.snz = 0;
        return s;
    endfunction

    // Called at a falling edge: drive one cycle, record what the next rising edge must produce.
    task automatic applyStimulus(input stim_t s);
        curH = s.hr; curM = s.mn; curS = s.sc;
        sec_tick = s.tick;
        hour = s.hr; min = s.mn; sec = s.sc;
        wr_en = s.we; wr_slot = 2'(s.ws);
        wr_hour = s.wh; wr_min = s.wm; wr_sec = s.wsc; wr_arm = s.warm;
        dismiss = s.dis; snooze = s.snz;
        modelStep(s);
        expQ.push_back(modelView());
        @(negedge clk_src);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(idleStim());
    endtask

    task automatic writeSlot(input int slot, input int h, input int m, input int sc, input bit arm);
        stim_t s = idleStim();
        s.we = 1; s.ws = slot; s.wh = h; s.wm = m; s.wsc = sc; s.warm = arm;
        applyStimulus(s);
    endtask

    task automatic tickAt(input int h, input int m, input int sc);
        stim_t s = idleStim();
        s.tick = 1; s.hr = h; s.mn = m; s.sc = sc;
        applyStimulus(s);
    endtask

    task automatic press(input bit dis, input bit snz);
        stim_t s = idleStim();
        s.dis = dis; s.snz = snz;
        applyStimulus(s);
    endtask

    // Hour 99 is never programmed, so these ticks only advance timers.
    task automatic plainTicks(input int n);
        for (int i = 0; i < n; i++) begin
            tickAt(99, i / 60, i % 60);
            idle(1);
        end
    endtask

    task automatic doAsyncReset();
        stim_t s = idleStim();
        sec_tick = 0; wr_en = 0; dismiss = 0; snooze = 0;
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_ring", int'(sig_ring), 0);
        checkOutput("async_rst_armed", int'(armed), 0);
        checkOutput("async_rst_pending", int'(pending), 0);
        checkOutput("async_rst_active", int'(active_slot), 0);
        modelReset();
        curH = s.hr;
        expQ.push_back(modelView());
        @(negedge clk_src);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_src);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("sig_ring", int'(sig_ring), int'(e.ring));
                checkOutput("active_slot", int'(active_slot), e.active);
                checkOutput("armed", int'(armed), e.armedV);
                checkOutput("pending", int'(pending), e.pendV);
            end
        end
    end

    initial begin : stimulus
        int candH[4] = '{7, 12, 6, 13};
        int candM[4] = '{30, 0, 15, 45};
        int candS[4] = '{0, 0, 30, 59};
        stim_t s;
        int k;

        modelReset();
        #1 reset = 1'b1;
        #1;
        checkOutput("por_ring", int'(sig_ring), 0);
        checkOutput("por_armed", int'(armed), 0);
        checkOutput("por_pending", int'(pending), 0);
        checkOutput("por_active", int'(active_slot), 0);
        @(negedge clk_src);
        reset = 1'b0;

        idle(2);
        writeSlot(2, 7, 30, 0, 1);
        tickAt(7, 29, 59);
        idle(1);
        tickAt(7, 30, 0);
        idle(2);
        plainTicks(RING_LEN);
        idle(2);

        writeSlot(1, 12, 0, 0, 1);
        writeSlot(3, 12, 0, 0, 1);
        tickAt(12, 0, 0);
        idle(3);
        press(1, 0);
        idle(3);
        press(1, 0);
        idle(2);

        tickAt(12, 0, 0);
        idle(2);
        press(0, 1);
        idle(2);
        press(0, 1);
        plainTicks(SNOOZE_LEN);
        idle(2);
        press(1, 1);
        idle(3);
        press(1, 0);
        idle(2);

        writeSlot(0, 5, 0, 0, 0);
        tickAt(5, 0, 0);
        idle(2);
        writeSlot(0, 6, 0, 0, 1);
        tickAt(6, 0, 0);
        idle(2);
        writeSlot(0, 6, 0, 0, 0);
        idle(2);

        writeSlot(1, 13, 0, 0, 1);
        s = idleStim();
        s.tick = 1; s.hr = 13; s.mn = 0; s.sc = 0;
        s.we = 1; s.ws = 1; s.wh = 13; s.wm = 0; s.wsc = 0; s.warm = 1;
        applyStimulus(s);
        idle(2);

        tickAt(7, 30, 0);
        idle(3);
        doAsyncReset();
        idle(2);
        writeSlot(2, 7, 30, 0, 1);
        tickAt(7, 30, 0);
        idle(2);
        press(0, 1);
        plainTicks(5);
        doAsyncReset();
        idle(2);

        for (int n = 0; n < 4000; n++) begin
            s = idleStim();
            if ($urandom_range(0, 2) == 0) begin
                s.tick = 1;
                k = $urandom_range(0, 7);
                if (k < 4) begin
                    s.hr = candH[k]; s.mn = candM[k]; s.sc = candS[k];
                end else begin
                    s.hr = $urandom_range(0, 23); s.mn = $urandom_range(0, 59); s.sc = $urandom_range(0, 59);
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                k = $urandom_range(0, 3);
                s.we = 1; s.ws = $urandom_range(0, 3);
                s.wh = candH[k]; s.wm = candM[k]; s.wsc = candS[k];
                s.warm = ($urandom_range(0, 3) != 0);
            end
            s.dis = ($urandom_range(0, 24) == 0);
            s.snz = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1499) == 0) doAsyncReset();
            else applyStimulus(s);
        end

        idle(1);
        @(negedge clk_src);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
